// File: rtl/synapse_irq_pkg.sv
// Shared types and limits for the synapse interrupt arbiter.
package synapse_irq_pkg;

  localparam int unsigned IRQ_CODE_W     = 16;
  localparam int unsigned IRQ_MAX_INPUTS = 65535;
  localparam int unsigned IRQ_MAX_SYNC   = 3;

  typedef logic [IRQ_CODE_W-1:0] irq_code_t;

  typedef enum logic [0:0] {
    IRQ_IDLE  = 1'b0,
    IRQ_OFFER = 1'b1
  } irq_state_e;

  // Offer presented to the consumer.
  typedef struct packed {
    logic      valid;
    irq_code_t code;
  } irq_offer_t;

endpackage

// File: rtl/irq_pick_highest.sv
// Combinational priority pick: highest set index of the candidate vector wins.
module irq_pick_highest
  import synapse_irq_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 16
) (
  input  logic [NUM_INPUTS-1:0] cand,
  output logic                  any_c,
  output irq_code_t             win_c
);

  // Later (higher) indices overwrite earlier ones, so the last hit is the winner.
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (cand[i]) begin
        win_c = IRQ_CODE_W'(i);
      end
    end
  end

  assign any_c = |cand;

endmodule

// File: rtl/irq_priority_arbiter.sv
// Interrupt arbiter: optional input synchroniser, edge/level pending capture,
// enable masking and a registered valid/ack offer of the most urgent source.
module irq_priority_arbiter
  import synapse_irq_pkg::*;
#(
  parameter int unsigned           NUM_INPUTS  = 16,
  parameter logic [NUM_INPUTS-1:0] EDGE_MASK   = '1,
  parameter int unsigned           SYNC_STAGES = 0
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic [NUM_INPUTS-1:0] in,
  input  logic [NUM_INPUTS-1:0] enable_mask,
  input  logic                  clear_all,
  input  logic                  irq_ack,
  output logic                  irq_valid,
  output logic [IRQ_CODE_W-1:0] irq_code,
  output logic [NUM_INPUTS-1:0] pending
);

  logic [NUM_INPUTS-1:0] s;
  logic [NUM_INPUTS-1:0] edge_hist_q, edge_hist_d;
  logic [NUM_INPUTS-1:0] pending_q, pending_d;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] cand;
  logic [NUM_INPUTS-1:0] code_hit;
  irq_state_e            state_q, state_d;
  irq_offer_t            offer_q, offer_d;
  logic                  any;
  irq_code_t             win;
  logic                  ack_take;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INPUTS-1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= '0;
        end
      end else begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_d[k];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign edge_hist_d = s;
  assign rise        = s & ~edge_hist_q;
  assign cand        = pending_q & enable_mask;
  assign ack_take    = (state_q == IRQ_OFFER) && irq_ack;

  // One-hot decode of the code currently on offer.
  always_comb begin
    code_hit = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      code_hit[i] = (offer_q.code == IRQ_CODE_W'(i));
    end
  end

  // Pending capture: clear_all beats a new edge, a new edge beats an ack-clear.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (EDGE_MASK[i]) begin
        if (clear_all) begin
          pending_d[i] = 1'b0;
        end else if (rise[i]) begin
          pending_d[i] = 1'b1;
        end else if (ack_take && code_hit[i]) begin
          pending_d[i] = 1'b0;
        end
      end else begin
        pending_d[i] = s[i];
      end
    end
  end

  irq_pick_highest #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_pick (
    .cand  (cand),
    .any_c (any),
    .win_c (win)
  );

  // Offer FSM: code is frozen while offered; any exit passes through IDLE.
  always_comb begin
    state_d = state_q;
    offer_d = offer_q;
    case (state_q)
      IRQ_IDLE: begin
        if (any) begin
          offer_d.code  = win;
          offer_d.valid = 1'b1;
          state_d       = IRQ_OFFER;
        end
      end
      IRQ_OFFER: begin
        if (clear_all || irq_ack || !(|(cand & code_hit))) begin
          offer_d.valid = 1'b0;
          state_d       = IRQ_IDLE;
        end
      end
      default: begin
        offer_d.valid = 1'b0;
        state_d       = IRQ_IDLE;
      end
    endcase
  end

  // Edge history resets high so a source already asserted at release raises no edge.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q     <= IRQ_IDLE;
      offer_q     <= '0;
      pending_q   <= '0;
      edge_hist_q <= '1;
    end else begin
      state_q     <= state_d;
      offer_q     <= offer_d;
      pending_q   <= pending_d;
      edge_hist_q <= edge_hist_d;
    end
  end

  assign irq_valid = offer_q.valid;
  assign irq_code  = offer_q.code;
  assign pending   = pending_q;

  param_range_a : assert property (@(posedge sysclk)
    (NUM_INPUTS >= 2) && (NUM_INPUTS <= IRQ_MAX_INPUTS) && (SYNC_STAGES <= IRQ_MAX_SYNC))
    else $error("irq_priority_arbiter: parameter out of range");

endmodule
